// File: rtl/trivium_seq_if.sv
// Keystream word stream between the Trivium sequencer and its consumer.
// The master drives word/valid; the slave answers with ready.
interface trivium_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] ks_word;
    logic             ks_valid;
    logic             ks_ready;

    modport master (output ks_word, output ks_valid, input ks_ready);
    modport slave  (input ks_word, input ks_valid, output ks_ready);
endinterface

// File: rtl/trivium_seq.sv
// Trivium keystream sequencer: load strobe, discarded warm-up rounds, then LSB-first
// packing of keystream bits into words, with the core frozen while a word is pending.
module trivium_seq #(
    parameter int unsigned WARMUP = 1152,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LENW   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [LENW-1:0]     len_i,
    output logic                core_load_o,
    output logic                core_step_o,
    input  logic                core_ks_i,
    trivium_seq_if.master       ks_if,
    output logic                busy_o,
    output logic                warmed_o,
    output logic                done_o
);

    localparam int unsigned WarmW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned BitW  = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StLoad, StWarm, StFill, StHold} state_e;

    state_e           state_q, state_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  wcnt_q, wcnt_d;
    logic [WarmW-1:0] warm_q, warm_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        warm_d  = warm_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        word_d  = word_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d = StLoad;
                    len_d   = len_i;
                    wcnt_d  = '0;
                end
            end
            StLoad: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWarm;
                    warm_d  = '0;
                end
            end
            StWarm: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else begin
                    warm_d = warm_q + WarmW'(1);
                    if (warm_q == WarmW'(WARMUP - 1)) begin
                        state_d = StFill;
                        bit_d   = '0;
                    end
                end
            end
            StFill: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else begin
                    // Right shift puts the first bit of the word at bit 0.
                    sh_d  = {core_ks_i, sh_q[WIDTH-1:1]};
                    bit_d = bit_q + BitW'(1);
                    if (bit_q == BitW'(WIDTH - 1)) begin
                        word_d  = sh_d;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                // stop wins over a same-cycle handshake: that word is not counted.
                if (stop_i) begin
                    state_d = StIdle;
                end else if (ks_if.ks_ready) begin
                    wcnt_d = wcnt_q + LENW'(1);
                    if (len_q != '0 && wcnt_d == len_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFill;
                        bit_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            len_q   <= '0;
            wcnt_q  <= '0;
            warm_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            warm_q  <= warm_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    assign core_load_o    = (state_q == StLoad);
    assign core_step_o    = (state_q == StWarm) || (state_q == StFill);
    assign ks_if.ks_valid = (state_q == StHold);
    assign ks_if.ks_word  = word_q;
    assign busy_o         = (state_q != StIdle);
    assign warmed_o       = (state_q == StFill) || (state_q == StHold);
    assign done_o         = done_q;

endmodule

// File: tb/tb_trivium_seq.sv
// Bench for trivium_seq: instance A uses the default warm-up for latency, instance B
// uses WARMUP=4 for packing, backpressure, abort and reset corner cases.
module tb_trivium_seq;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni = 1'b1;
    logic        start_a, start_b, stop, ready;
    logic        core_ks = 1'b0;
    logic [15:0] len;
    logic        load_a, step_a, busy_a, warmed_a, done_a;
    logic        load_b, step_b, busy_b, warmed_b, done_b;

    trivium_seq_if #(.WIDTH(8)) if_a ();
    trivium_seq_if #(.WIDTH(8)) if_b ();
    assign if_a.ks_ready = ready;
    assign if_b.ks_ready = ready;

    trivium_seq #(.WARMUP(1152), .WIDTH(8), .LENW(16)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_a), .stop_i(stop), .len_i(len),
        .core_load_o(load_a), .core_step_o(step_a), .core_ks_i(core_ks), .ks_if(if_a),
        .busy_o(busy_a), .warmed_o(warmed_a), .done_o(done_a)
    );

    trivium_seq #(.WARMUP(4), .WIDTH(8), .LENW(16)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_b), .stop_i(stop), .len_i(len),
        .core_load_o(load_b), .core_step_o(step_b), .core_ks_i(core_ks), .ks_if(if_b),
        .busy_o(busy_b), .warmed_o(warmed_b), .done_o(done_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Core model: feeds bits of 'feed' in time order (leftmost first) during FILL.
    logic [7:0] feed = 8'hB2;
    int         fidx = 0;
    always @(negedge clk_i) begin
        if (load_b) fidx = 0;
        else if (warmed_b && step_b) begin
            core_ks = feed[7-fidx];
            fidx    = (fidx + 1) % 8;
        end
    end

    int n_load_b = 0, n_step_b = 0, n_done_b = 0, n_acc_b = 0;
    always @(negedge clk_i) begin
        if (load_b) n_load_b++;
        if (step_b) n_step_b++;
        if (done_b) n_done_b++;
        if (if_b.ks_valid && ready) n_acc_b++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench in cycle 1 of the session (LOAD).
    task automatic start_session_b(input logic [15:0] l);
        len     = l;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] feed;
        logic [7:0] word;
    } vec_t;
    vec_t vecs[6];

    int   base_load, base_step, base_done, base_acc;
    int   first_load, first_step, last_step, first_valid, done_cyc, n_load_a, n_step_a;
    logic bad;
    logic [7:0] w0;

    initial begin
        start_a = 0; start_b = 0; stop = 0; ready = 0; len = 0;
        vecs[0] = '{feed: 8'b1011_0010, word: 8'h4D};
        vecs[1] = '{feed: 8'b1000_0000, word: 8'h01};
        vecs[2] = '{feed: 8'b0000_0001, word: 8'h80};
        vecs[3] = '{feed: 8'b1111_0000, word: 8'h0F};
        vecs[4] = '{feed: 8'b1100_1010, word: 8'h53};
        vecs[5] = '{feed: 8'b1111_1111, word: 8'hFF};

        // Reset and idle
        #2 rst_ni = 1'b0;
        #20 rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_a || step_a || busy_a || warmed_a || done_a || if_a.ks_valid ||
                load_b || step_b || busy_b || warmed_b || done_b || if_b.ks_valid ||
                if_a.ks_word != 0 || if_b.ks_word != 0) bad = 1;
        end
        chk("reset_idle_outputs", {31'b0, bad}, 0);
        chk("reset_no_strobes", n_load_b + n_step_b, 0);

        // Latency with default warm-up
        ready = 1; len = 1;
        first_load = -1; first_step = -1; last_step = -1; first_valid = -1; done_cyc = -1;
        n_load_a = 0; n_step_a = 0;
        start_a = 1;
        for (int cyc = 1; cyc <= 1170; cyc++) begin
            tick();
            if (cyc == 1) start_a = 0;
            if (load_a) begin n_load_a++; if (first_load < 0) first_load = cyc; end
            if (step_a) begin n_step_a++; if (first_step < 0) first_step = cyc; last_step = cyc; end
            if (if_a.ks_valid && first_valid < 0) first_valid = cyc;
            if (done_a) done_cyc = cyc;
        end
        chk("lat_load_cycle", first_load, 1);
        chk("lat_load_count", n_load_a, 1);
        chk("lat_step_count", n_step_a, 1160);
        chk("lat_first_step", first_step, 2);
        chk("lat_last_step", last_step, 1161);
        chk("lat_first_valid", first_valid, 1162);
        chk("lat_done_cycle", done_cyc, 1163);
        chk("lat_idle_after", {31'b0, busy_a}, 0);

        // Packing order, table-driven
        ready = 1;
        foreach (vecs[i]) begin
            feed = vecs[i].feed;
            base_done = n_done_b;
            start_session_b(1);
            for (int k = 0; k < 40 && !if_b.ks_valid; k++) tick();
            chk($sformatf("pack_valid_%0d", i), {31'b0, if_b.ks_valid}, 1);
            chk($sformatf("pack_word_%0d", i), {24'b0, if_b.ks_word}, {24'b0, vecs[i].word});
            for (int k = 0; k < 10 && busy_b; k++) tick();
            tick();
            chk($sformatf("pack_done_%0d", i), n_done_b - base_done, 1);
        end

        // Backpressure, len=3
        feed = 8'b1011_0010;
        ready = 0;
        base_step = n_step_b; base_done = n_done_b; base_acc = n_acc_b; base_load = n_load_b;
        start_session_b(3);
        for (int k = 0; k < 40 && !if_b.ks_valid; k++) tick();
        w0 = if_b.ks_word;
        chk("bp_first_word", {24'b0, w0}, 32'h4D);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (if_b.ks_word != w0 || step_b || !if_b.ks_valid) bad = 1;
        end
        chk("bp_hold_stable", {31'b0, bad}, 0);
        ready = 1;
        bad = 0;
        for (int k = 0; k < 200 && busy_b; k++) begin
            if (if_b.ks_valid && if_b.ks_word != 8'h4D) bad = 1;
            tick();
        end
        tick();
        chk("bp_words_ok", {31'b0, bad}, 0);
        chk("bp_word_count", n_acc_b - base_acc, 3);
        chk("bp_done_count", n_done_b - base_done, 1);
        chk("bp_step_count", n_step_b - base_step, 28);
        chk("bp_load_count", n_load_b - base_load, 1);

        // Abort during WARM
        base_done = n_done_b;
        start_session_b(0);
        tick();
        chk("abort_warm_stepping", {31'b0, step_b}, 1);
        stop = 1;
        tick();
        stop = 0;
        chk("abort_warm_idle", {29'b0, busy_b, step_b, if_b.ks_valid}, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("abort_warm_no_done", n_done_b - base_done, 0);

        // Abort during HOLD with a simultaneous handshake
        ready = 0;
        start_session_b(0);
        for (int k = 0; k < 40 && !if_b.ks_valid; k++) tick();
        chk("abort_hold_reached", {31'b0, if_b.ks_valid}, 1);
        ready = 1; stop = 1;
        tick();
        stop = 0;
        chk("abort_hold_idle", {29'b0, busy_b, step_b, if_b.ks_valid}, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("abort_hold_no_done", n_done_b - base_done, 0);

        // Restart after abort
        start_session_b(0);
        chk("restart_load", {31'b0, load_b}, 1);
        stop = 1;
        tick();
        stop = 0;
        tick();

        // start and stop together in IDLE
        base_load = n_load_b;
        start_b = 1; stop = 1;
        tick();
        start_b = 0; stop = 0;
        chk("start_stop_idle", {30'b0, busy_b, load_b}, 0);
        tick();
        chk("start_stop_no_load", n_load_b - base_load, 0);

        // start during FILL is ignored
        base_load = n_load_b; base_done = n_done_b; base_acc = n_acc_b;
        ready = 1;
        start_session_b(1);
        for (int k = 0; k < 40 && !(warmed_b && step_b); k++) tick();
        start_b = 1;
        tick();
        start_b = 0;
        for (int k = 0; k < 40 && busy_b; k++) tick();
        for (int k = 0; k < 5; k++) tick();
        chk("fill_start_loads", n_load_b - base_load, 1);
        chk("fill_start_done", n_done_b - base_done, 1);
        chk("fill_start_words", n_acc_b - base_acc, 1);

        // Async reset in FILL
        start_session_b(0);
        for (int k = 0; k < 40 && !(warmed_b && step_b); k++) tick();
        chk("rst_in_fill_reached", {31'b0, warmed_b}, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_outputs",
            {24'b0, if_b.ks_word}
                | {26'b0, busy_b, step_b, load_b, warmed_b, done_b, if_b.ks_valid}, 0);
        #10 rst_ni = 1'b1;
        base_load = n_load_b; base_step = n_step_b; base_done = n_done_b;
        for (int k = 0; k < 20; k++) tick();
        chk("rst_no_strobes", (n_load_b - base_load) + (n_step_b - base_step)
                              + (n_done_b - base_done), 0);
        chk("rst_idle", {31'b0, busy_b}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
